// File: rtl/logistic_snd_mix.sv
// Multi-voice logistic-map tone generator: N_OSC voices share one multiplier to iterate
// x' = r*x*(1-x) once per pass, drive square-wave oscillators, and mix to a sigma-delta bit.

module logistic_snd_voice #(
    parameter int FRAC       = 16,
    parameter int PHASE_BITS = 16,
    parameter int FREQ_RES   = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [FRAC-1:0] x_i,
    output logic            sq_o
);
    logic [PHASE_BITS-1:0] phase_q, phase_d;
    logic [FRAC-1:0]       inc;

    assign inc     = x_i >> FREQ_RES;
    assign phase_d = phase_q + PHASE_BITS'(inc);
    assign sq_o    = phase_q[PHASE_BITS-1];

    always_ff @(posedge clk) begin
        if (reset) phase_q <= '0;
        else       phase_q <= phase_d;
    end
endmodule

module logistic_snd_mix #(
    parameter int N_OSC      = 8,
    parameter int ITER_LEN   = 15361,
    parameter int R_INC      = 2,
    parameter int FRAC       = 16,
    parameter int R_MIN      = 3 << FRAC,
    parameter int PHASE_BITS = 16,
    parameter int FREQ_RES   = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_OSC-1:0]           osc_en,
    input  logic                       mute,
    input  logic                       freeze,
    output logic                       snd,
    output logic [$clog2(N_OSC+1)-1:0] mix,
    output logic [FRAC+1:0]            r_out,
    output logic                       iter_strobe
);
    localparam int MW = $clog2(N_OSC + 1);
    localparam int KW = (N_OSC > 1) ? $clog2(N_OSC) : 1;
    localparam int CW = $clog2(ITER_LEN);
    localparam int RW = FRAC + 2;
    localparam int PW = 2 * RW;
    localparam logic [RW-1:0] ONE   = RW'(1) << FRAC;
    localparam logic [RW:0]   R_TOP = (RW+1)'(1) << (FRAC + 2);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL1 = 3'd1;
    localparam logic [2:0] S_MUL2 = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    function automatic logic [FRAC-1:0] seed(input int k);
        logic [63:0] num;
        num = 64'(2 * k + 1) << FRAC;
        return FRAC'(num / 64'(2 * N_OSC));
    endfunction

    logic [2:0]                  state_q, state_d;
    logic [KW-1:0]               k_q, k_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [RW-1:0]               r_q, r_d;
    logic [RW-1:0]               p_q, p_d;
    logic [FRAC-1:0]             y_q, y_d;
    logic [N_OSC-1:0][FRAC-1:0]  x_q, x_d;
    logic [MW-1:0]               mix_q, mix_d;
    logic [MW-1:0]               acc_q, acc_d;
    logic                        snd_q, snd_d;
    logic [FRAC-1:0]             x_cur;
    logic [RW-1:0]               mul_a, mul_b, prod_hi;
    logic [RW:0]                 r_sum;
    logic [MW:0]                 sd_sum;
    logic [N_OSC-1:0]            sq;
    logic                        cnt_end;

    always_comb begin
        x_cur = '0;
        for (int i = 0; i < N_OSC; i++)
            if (k_q == KW'(i)) x_cur = x_q[i];
    end

    // One multiplier: x*(1-x) in MUL1, r*p in MUL2; both results are Q.FRAC after the shift
    assign mul_a   = (state_q == S_MUL1) ? RW'(x_cur) : r_q;
    assign mul_b   = (state_q == S_MUL1) ? ONE - RW'(x_cur) : p_q;
    assign prod_hi = RW'((PW'(mul_a) * PW'(mul_b)) >> FRAC);
    assign r_sum   = {1'b0, r_q} + (RW+1)'(R_INC);
    assign cnt_end = (cnt_q == CW'(ITER_LEN - 1));

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        p_d     = p_q;
        y_d     = y_q;
        r_d     = r_q;
        x_d     = x_q;
        cnt_d   = cnt_end ? '0 : cnt_q + 1'b1;
        case (state_q)
            S_IDLE: if (cnt_end) begin
                state_d = S_MUL1;
                k_d     = '0;
            end
            S_MUL1: begin
                p_d     = prod_hi;
                state_d = S_MUL2;
            end
            S_MUL2: begin
                y_d     = prod_hi[FRAC-1:0];
                state_d = S_WR;
            end
            S_WR: begin
                for (int i = 0; i < N_OSC; i++)
                    if (k_q == KW'(i)) x_d[i] = y_q;
                if (k_q == KW'(N_OSC - 1)) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = S_MUL1;
                end
            end
            S_DONE: begin
                if (!freeze) r_d = (r_sum >= R_TOP) ? RW'(R_MIN) : r_sum[RW-1:0];
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    for (genvar g = 0; g < N_OSC; g++) begin : g_voice
        logistic_snd_voice #(
            .FRAC(FRAC), .PHASE_BITS(PHASE_BITS), .FREQ_RES(FREQ_RES)
        ) u_voice (
            .clk(clk), .reset(reset), .x_i(x_q[g]), .sq_o(sq[g])
        );
    end

    always_comb begin
        mix_d = '0;
        for (int i = 0; i < N_OSC; i++)
            mix_d = mix_d + MW'(sq[i] & osc_en[i]);
    end

    // First-order sigma-delta; acc stays in [0, N_OSC)
    assign sd_sum = {1'b0, acc_q} + {1'b0, mix_q};

    always_comb begin
        if (sd_sum >= (MW+1)'(N_OSC)) begin
            snd_d = 1'b1;
            acc_d = MW'(sd_sum - (MW+1)'(N_OSC));
        end else begin
            snd_d = 1'b0;
            acc_d = sd_sum[MW-1:0];
        end
        if (mute) begin
            snd_d = 1'b0;
            acc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            r_q     <= RW'(R_MIN);
            p_q     <= '0;
            y_q     <= '0;
            for (int i = 0; i < N_OSC; i++) x_q[i] <= seed(i);
            mix_q   <= '0;
            acc_q   <= '0;
            snd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            p_q     <= p_d;
            y_q     <= y_d;
            x_q     <= x_d;
            mix_q   <= mix_d;
            acc_q   <= acc_d;
            snd_q   <= snd_d;
        end
    end

    assign snd         = snd_q;
    assign mix         = mix_q;
    assign r_out       = r_q;
    assign iter_strobe = (state_q == S_DONE);
endmodule

// File: tb/tb_logistic_snd_mix.sv
// Directed bench for logistic_snd_mix: r sweep/wrap/freeze table, x iteration timing,
// silence, fixed-mix sigma-delta pattern, mute and mid-pass reset.

module tb_logistic_snd_mix;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mute = 1'b0;
    logic freeze = 1'b0;
    logic osc1 = 1'b0;
    logic [7:0] osc8 = '0, oscq = '0;

    logic snd1, snd2, snd3, snd8, sndq;
    logic mix1, mix2, mix3;
    logic [3:0] mix8, mixq;
    logic [17:0] r1, r2, r3, r8, rq;
    logic stb1, stb2, stb3, stb8, stbq;

    int checks = 0;
    int errors = 0;
    int e = 0;

    always #5 clk = ~clk;

    logistic_snd_mix #(.N_OSC(1), .ITER_LEN(40), .R_INC(2)) u1 (
        .clk(clk), .reset(reset), .osc_en(osc1), .mute(mute), .freeze(freeze),
        .snd(snd1), .mix(mix1), .r_out(r1), .iter_strobe(stb1));
    logistic_snd_mix #(.N_OSC(1), .ITER_LEN(40), .R_INC(65536)) u2 (
        .clk(clk), .reset(reset), .osc_en(osc1), .mute(mute), .freeze(freeze),
        .snd(snd2), .mix(mix2), .r_out(r2), .iter_strobe(stb2));
    logistic_snd_mix #(.N_OSC(1), .ITER_LEN(40), .R_INC(32768)) u3 (
        .clk(clk), .reset(reset), .osc_en(osc1), .mute(mute), .freeze(freeze),
        .snd(snd3), .mix(mix3), .r_out(r3), .iter_strobe(stb3));
    logistic_snd_mix #(.N_OSC(8), .ITER_LEN(64), .R_INC(2)) u8 (
        .clk(clk), .reset(reset), .osc_en(osc8), .mute(mute), .freeze(freeze),
        .snd(snd8), .mix(mix8), .r_out(r8), .iter_strobe(stb8));
    // Voice k steps its phase by k per clock, so sq = 8'hF0 for clocks ~8192..9362
    logistic_snd_mix #(.N_OSC(8), .ITER_LEN(20000), .R_INC(2), .FREQ_RES(13)) uq (
        .clk(clk), .reset(reset), .osc_en(oscq), .mute(mute), .freeze(freeze),
        .snd(sndq), .mix(mixq), .r_out(rq), .iter_strobe(stbq));

    typedef struct {
        bit frz;
        int gap;
        int r1;
        int r2;
        int r3;
    } pass_vec_t;

    task automatic step();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        e = 0;
    endtask

    // Phase of the single u1 voice after edge ee: x=0.5 until the first WR edge (43), then 0.75
    function automatic bit sq1(input int ee);
        longint ph;
        if (ee <= 43) ph = longint'(ee) * 32768;
        else          ph = 43 * 32768 + longint'(ee - 43) * 49152;
        return ph[15];
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit");
        $fatal(1, "timeout");
    end

    initial begin
        pass_vec_t tbl[6];
        int first_stb, last_e, n, bad, nstb, prev;
        bit seq[5];

        tbl[0] = '{1'b0, 43, 196610, 196608, 229376};
        tbl[1] = '{1'b1, 40, 196610, 196608, 229376};
        tbl[2] = '{1'b1, 40, 196610, 196608, 229376};
        tbl[3] = '{1'b1, 40, 196610, 196608, 229376};
        tbl[4] = '{1'b0, 40, 196612, 196608, 196608};
        tbl[5] = '{1'b0, 40, 196614, 196608, 229376};

        // Reset values
        do_reset();
        chk("rst_snd", {snd1, snd2, snd3, snd8, sndq}, 0);
        chk("rst_mix", {mix1, mix2, mix3, mix8, mixq}, 0);
        chk("rst_stb", {stb1, stb2, stb3, stb8, stbq}, 0);
        chk("rst_r1", r1, 196608);
        chk("rst_r8", r8, 196608);
        chk("rst_rq", rq, 196608);
        chk("rst_r23", {r2, r3}, {18'd196608, 18'd196608});

        // x iteration timing seen through the u1 square wave
        osc1 = 1'b1;
        do_reset();
        first_stb = -1;
        for (int i = 1; i <= 60; i++) begin
            step();
            chk($sformatf("u1_mix_e%0d", e), mix1, sq1(e - 1));
            if (stb1 && first_stb < 0) first_stb = e;
            if (e == 44) chk("u1_r_after_pass1", r1, 196610);
        end
        chk("u1_first_strobe", first_stb, 43);

        // r sweep, wrap and freeze, one table entry per pass
        do_reset();
        last_e = 0;
        for (int i = 0; i < 6; i++) begin
            freeze = tbl[i].frz;
            n = 0;
            while (!stb1 && n < 100) begin
                step();
                n++;
            end
            chk($sformatf("pass%0d_gap", i), e - last_e, tbl[i].gap);
            chk($sformatf("pass%0d_stb23", i), {stb2, stb3}, 2'b11);
            last_e = e;
            step();
            chk($sformatf("pass%0d_stb_pulse", i), stb1, 0);
            chk($sformatf("pass%0d_r1", i), r1, tbl[i].r1);
            chk($sformatf("pass%0d_r2", i), r2, tbl[i].r2);
            chk($sformatf("pass%0d_r3", i), r3, tbl[i].r3);
        end
        freeze = 1'b0;

        // Silence with all voices disabled; mute pulses leave the strobe cadence alone
        osc8 = '0;
        do_reset();
        bad = 0;
        nstb = 0;
        first_stb = -1;
        for (int i = 0; i < 10000; i++) begin
            mute = ((e % 1000) == 500);
            step();
            if (mix8 != 0 || snd8 != 0) bad++;
            if (stb8) begin
                nstb++;
                if (first_stb < 0) first_stb = e;
            end
        end
        mute = 1'b0;
        chk("u8_silent_cycles_bad", bad, 0);
        chk("u8_first_strobe", first_stb, 88);
        chk("u8_strobe_count", nstb, (10000 - 88) / 64 + 1);

        // Fixed mix of 4 out of 8: snd alternates
        oscq = 8'hFF;
        do_reset();
        while (e < 8400) step();
        prev = sndq;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (mixq != 4) bad++;
            if (sndq == prev) bad++;
            prev = sndq;
        end
        chk("uq_mix4_alt_bad", bad, 0);

        // Mute while acc holds 4..7: output restarts from acc=0
        n = 0;
        while (sndq != 1'b0 && n < 4) begin
            step();
            n++;
        end
        chk("uq_pre_mute_snd", sndq, 0);
        mute = 1'b1;
        step();
        mute = 1'b0;
        chk("uq_mute_snd", sndq, 0);
        seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("uq_post_mute_%0d", i), sndq, seq[i]);
        end
        chk("uq_mix_still4", mixq, 4);

        // Reset during MUL2 of voice 3 (pass begins at edge 64, 3 edges per voice)
        osc8 = 8'hFF;
        do_reset();
        bad = 0;
        while (e < 74) begin
            step();
            if (stb8) bad++;
        end
        chk("u8_no_early_strobe", bad, 0);
        reset = 1'b1;
        step();
        chk("u8_midrst_snd", snd8, 0);
        chk("u8_midrst_mix", mix8, 0);
        chk("u8_midrst_stb", stb8, 0);
        chk("u8_midrst_r", r8, 196608);
        reset = 1'b0;
        e = 0;
        n = 0;
        while (!stb8 && n < 200) begin
            step();
            n++;
        end
        chk("u8_strobe_after_midrst", e, 88);
        step();
        chk("u8_r_after_midrst", r8, 196610);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
